// File: rtl/perf_counter_bank.sv
// Bank of measurement sections. Each section has a time counter, a saturating event counter,
// a run bit and a sticky overflow flag. The high time word is snapshotted when the low word is read.
module perf_counter_bank #(
  parameter int NUM_SECTIONS = 4,
  parameter int CNT_WIDTH    = 64,
  parameter int EVT_WIDTH    = 32,
  localparam int AW          = $clog2(NUM_SECTIONS * 4)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [AW-1:0]           address,
  input  logic                    begintransfer,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_SECTIONS-1:0] overflow
);

  localparam int SW        = CNT_WIDTH - 32;
  localparam int LIMIT_INT = 4 * NUM_SECTIONS;
  localparam logic [AW:0] LIMIT = LIMIT_INT[AW:0];
  localparam logic [EVT_WIDTH-1:0] EVT_MAX = '1;

  logic                    writeStrobe;
  logic                    readStrobe;
  logic                    inRange;
  logic                    globalReset;
  logic                    globalEnable;
  logic [AW:0]             addrExt;
  logic [AW:0]             secIdx;
  logic [1:0]              word;
  logic [NUM_SECTIONS-1:0] goVec;
  logic [NUM_SECTIONS-1:0] stopVec;
  logic [NUM_SECTIONS-1:0] clrVec;
  logic [NUM_SECTIONS-1:0] snapVec;
  logic [NUM_SECTIONS-1:0] runVec;
  logic [31:0]             cntLow  [NUM_SECTIONS];
  logic [SW-1:0]           snapArr [NUM_SECTIONS];
  logic [EVT_WIDTH-1:0]    evtArr  [NUM_SECTIONS];
  logic [31:0]             rdata_d;
  logic [31:0]             rdata_q;
  logic                    unusedWdata;

  assign writeStrobe  = write & begintransfer;
  assign readStrobe   = read & begintransfer;
  assign addrExt      = {1'b0, address};
  assign secIdx       = addrExt >> 2;
  assign word         = address[1:0];
  assign inRange      = addrExt < LIMIT;
  assign globalReset  = writeStrobe & (address == '0) & writedata[0];
  assign globalEnable = runVec[0] | goVec[0];
  assign unusedWdata  = ^writedata[31:1];

  always_comb begin
    goVec   = '0;
    stopVec = '0;
    clrVec  = '0;
    snapVec = '0;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      if (inRange && secIdx == s[AW:0]) begin
        stopVec[s] = writeStrobe && word == 2'd0;
        goVec[s]   = writeStrobe && word == 2'd1;
        clrVec[s]  = writeStrobe && word == 2'd3 && writedata[0];
        snapVec[s] = readStrobe && word == 2'd0;
      end
    end
  end

  for (genvar s = 0; s < NUM_SECTIONS; s++) begin : gen_sec
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [EVT_WIDTH-1:0] evt_q, evt_d;
    logic [SW-1:0]        snap_q, snap_d;
    logic                 run_q, run_d;
    logic                 ovf_q, ovf_d;
    logic                 tick;
    logic                 wrap;

    assign tick = run_q & globalEnable;
    assign wrap = tick & (cnt_q == '1);

    // A wrap in the same cycle as an overflow-clear write keeps the flag set.
    always_comb begin
      cnt_d  = tick ? cnt_q + CNT_WIDTH'(1) : cnt_q;
      evt_d  = (goVec[s] && evt_q != EVT_MAX) ? evt_q + EVT_WIDTH'(1) : evt_q;
      snap_d = snapVec[s] ? cnt_q[CNT_WIDTH-1:32] : snap_q;
      run_d  = run_q;
      if (goVec[s]) run_d = 1'b1;
      else if (stopVec[s]) run_d = 1'b0;
      ovf_d = ovf_q;
      if (wrap) ovf_d = 1'b1;
      else if (clrVec[s]) ovf_d = 1'b0;
      if (globalReset) begin
        cnt_d  = '0;
        evt_d  = '0;
        snap_d = '0;
        run_d  = 1'b0;
        ovf_d  = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        evt_q  <= '0;
        snap_q <= '0;
        run_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        evt_q  <= evt_d;
        snap_q <= snap_d;
        run_q  <= run_d;
        ovf_q  <= ovf_d;
      end
    end

    assign cntLow[s]   = cnt_q[31:0];
    assign snapArr[s]  = snap_q;
    assign evtArr[s]   = evt_q;
    assign runVec[s]   = run_q;
    assign overflow[s] = ovf_q;
  end

  always_comb begin
    rdata_d = '0;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      if (inRange && secIdx == s[AW:0]) begin
        case (word)
          2'd0:    rdata_d = cntLow[s];
          2'd1:    rdata_d = 32'(snapArr[s]);
          2'd2:    rdata_d = 32'(evtArr[s]);
          default: rdata_d = {30'b0, overflow[s], runVec[s]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign readdata = rdata_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: directed scenarios plus a random bus phase,
// all compared against a behavioural model of the sections kept in plain arrays.
module tb_perf_counter_bank;

  localparam int NS = 3;
  localparam int CW = 33;
  localparam int EW = 2;
  localparam int AW = 4;
  localparam longint unsigned TMAX = (64'd1 << CW) - 64'd1;
  localparam int EMAX = (1 << EW) - 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [AW-1:0]  address = '0;
  logic           begintransfer = 1'b0;
  logic           read = 1'b0;
  logic           write = 1'b0;
  logic [31:0]    writedata = '0;
  logic [31:0]    readdata;
  logic [NS-1:0]  overflow;

  always #5 clk = ~clk;

  perf_counter_bank #(
    .NUM_SECTIONS(NS),
    .CNT_WIDTH(CW),
    .EVT_WIDTH(EW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .begintransfer(begintransfer),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .overflow(overflow)
  );

  longint unsigned mTime [NS];
  int              mEvt  [NS];
  int unsigned     mSnap [NS];
  bit              mRun  [NS];
  bit              mOvf  [NS];
  int              compared = 0;
  int              mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < NS; i++) begin
      mTime[i] = 0; mEvt[i] = 0; mSnap[i] = 0; mRun[i] = 0; mOvf[i] = 0;
    end
  endfunction

  function automatic logic [NS-1:0] modelOvf();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = mOvf[i];
    return v;
  endfunction

  function automatic logic [31:0] modelRead(input int a);
    int s = a / 4;
    int w = a % 4;
    if (a >= 4 * NS) return 32'h0;
    case (w)
      0:       return 32'(mTime[s] % 64'h1_0000_0000);
      1:       return mSnap[s];
      2:       return 32'(mEvt[s]);
      default: return {30'b0, mOvf[s], mRun[s]};
    endcase
  endfunction

  // One clock edge of section behaviour, derived from the register-map rules.
  function automatic void modelStep(input int a, input bit bt, input bit rd, input bit wr,
                                    input logic [31:0] wd);
    bit ws = wr && bt;
    bit rs = rd && bt;
    bit inR = a < 4 * NS;
    int s = a / 4;
    int w = a % 4;
    bit en;
    bit wrapped [NS];
    if (ws && a == 0 && wd[0]) begin
      modelClear();
      return;
    end
    en = mRun[0] || (ws && a == 1);
    if (rs && inR && w == 0) mSnap[s] = int'(mTime[s] / 64'h1_0000_0000);
    for (int i = 0; i < NS; i++) begin
      wrapped[i] = 0;
      if (mRun[i] && en) begin
        mTime[i] = (mTime[i] + 1) % (TMAX + 1);
        if (mTime[i] == 0) begin
          mOvf[i] = 1;
          wrapped[i] = 1;
        end
      end
    end
    if (ws && inR) begin
      case (w)
        0: mRun[s] = 0;
        1: begin
          mRun[s] = 1;
          if (mEvt[s] < EMAX) mEvt[s]++;
        end
        3: if (wd[0] && !wrapped[s]) mOvf[s] = 0;
        default: ;
      endcase
    end
  endfunction

  task automatic applyStimulus(input int a, input bit bt, input bit rd, input bit wr,
                               input logic [31:0] wd, input string tag);
    logic [31:0] expRd;
    @(negedge clk);
    address = a[AW-1:0];
    begintransfer = bt;
    read = rd;
    write = wr;
    writedata = wd;
    expRd = modelRead(a);
    modelStep(a, bt, rd, wr, wd);
    @(posedge clk);
    #1;
    checkOutput({tag, ":readdata"}, readdata, expRd);
    checkOutput({tag, ":overflow"}, overflow, modelOvf());
  endtask

  task automatic writeWord(input int a, input logic [31:0] d);
    applyStimulus(a, 1, 0, 1, d, $sformatf("wr%0d", a));
  endtask

  task automatic readWord(input int a);
    applyStimulus(a, 1, 1, 0, 0, $sformatf("rd%0d", a));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, "idle");
  endtask

  // Reset is released in the middle of a held write with begintransfer low.
  task automatic doReset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    address = '0; begintransfer = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
    #1;
    checkOutput({tag, ":async_readdata"}, readdata, 0);
    checkOutput({tag, ":async_overflow"}, overflow, 0);
    modelClear();
    @(negedge clk);
    address = 4'd1;
    write = 1'b1;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    int a;
    bit bt, rd, wr;
    logic [31:0] wd;

    $display("[TB] start");
    modelClear();
    doReset("rst");
    applyStimulus(1, 0, 0, 1, 0, "noStrobe");
    applyStimulus(1, 0, 0, 1, 0, "noStrobe");
    readWord(3);
    readWord(3);
    checkOutput("rst:run0_after_midxfer", readdata, 0);

    writeWord(1, 0);
    idle(10);
    writeWord(0, 0);
    readWord(0);
    checkOutput("go_wait_stop:time0", readdata, 11);
    readWord(2);
    checkOutput("go_wait_stop:event0", readdata, 1);
    readWord(3);
    checkOutput("go_wait_stop:status0", readdata, 0);

    writeWord(5, 0);
    idle(3);
    readWord(4);
    checkOutput("go1_no_enable:time1", readdata, 0);
    writeWord(1, 0);
    idle(5);
    readWord(4);
    checkOutput("go1_enabled:time1", readdata, 6);

    #1 force dut.gen_sec[0].cnt_q = 33'h0_FFFF_FFFE;
    #1 release dut.gen_sec[0].cnt_q;
    mTime[0] = 64'h0_FFFF_FFFE;
    idle(2);
    readWord(0);
    checkOutput("tearfree:low", readdata, 0);
    readWord(1);
    checkOutput("tearfree:high", readdata, 1);
    checkOutput("tearfree:ovf0", overflow[0], 0);

    #1 force dut.gen_sec[0].cnt_q = 33'h1_FFFF_FFFD;
    #1 release dut.gen_sec[0].cnt_q;
    mTime[0] = TMAX - 2;
    idle(4);
    checkOutput("wrap:ovf0_set", overflow[0], 1);
    readWord(0);
    checkOutput("wrap:time0", readdata, 1);
    readWord(3);
    checkOutput("wrap:status0", readdata, 3);
    writeWord(3, 1);
    checkOutput("wrap:ovf0_cleared", overflow[0], 0);

    #1 force dut.gen_sec[0].cnt_q = 33'h1_FFFF_FFFE;
    #1 release dut.gen_sec[0].cnt_q;
    mTime[0] = TMAX - 1;
    idle(1);
    writeWord(3, 1);
    checkOutput("wrap_vs_clear:ovf0", overflow[0], 1);
    writeWord(3, 1);
    checkOutput("wrap_vs_clear:ovf0_later", overflow[0], 0);

    for (int i = 0; i < 4; i++) writeWord(9, 0);
    readWord(10);
    checkOutput("evt_saturate:event2", readdata, 3);

    for (int i = 0; i < 400; i++) begin
      a  = int'($urandom_range(0, 15));
      bt = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a == 0 && $urandom_range(0, 7) != 0) wd[0] = 1'b0;
      applyStimulus(a, bt, rd, wr, wd, "rand");
    end

    writeWord(1, 0);
    writeWord(5, 0);
    writeWord(9, 0);
    idle(3);
    writeWord(0, 1);
    checkOutput("greset:overflow", overflow, 0);
    for (int i = 0; i < 4 * NS; i++) begin
      readWord(i);
      checkOutput($sformatf("greset:word%0d", i), readdata, 0);
    end
    readWord(4 * NS);
    checkOutput("out_of_range:read", readdata, 0);

    writeWord(1, 0);
    idle(3);
    readWord(0);
    doReset("rst2");
    readWord(0);
    readWord(0);
    checkOutput("rst2:time0", readdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
